// File: rtl/mc_control_fsm_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_control_fsm_pkg : shared states, ALU/Op/condition encodings
// rev 1.0
// ------------------------------------------------------------------
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Data-processing cmd field to ALU operation; unsupported commands add.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    logic [1:0] op;
    case (cmd)
      CMD_ADD: op = ALU_ADD;
      CMD_SUB: op = ALU_SUB;
      CMD_AND: op = ALU_AND;
      CMD_ORR: op = ALU_ORR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_cond_check.sv
`default_nettype none
// ------------------------------------------------------------------
// cond_check : ARM condition-code evaluation against {N,Z,C,V}
// rev 1.0
// ------------------------------------------------------------------
module cond_check
  import mc_control_fsm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] flags,
  output logic       CondEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_control_fsm : multicycle ARM-subset control unit (Moore FSM)
// rev 1.0
// ------------------------------------------------------------------
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  state_o
);

  state_t     state;
  state_t     state_next;
  logic [3:0] flags;
  logic       cond_q;
  logic       cond_ex;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       rd_is_pc;
  logic [1:0] exec_alu;
  logic       in_exec;
  logic       flag_we;
  logic       flag_we_cv;
  logic       unused_instr;

  logic pc_w, ir_w, reg_w, mem_w;

  assign cond     = Instr[31:28];
  assign op       = Instr[27:26];
  assign funct    = Instr[25:20];
  assign rd       = Instr[15:12];
  assign rd_is_pc = (rd == 4'hF);
  assign exec_alu = alu_decode(funct[4:1]);

  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  cond_check u_cond_check (
    .Cond   (cond),
    .flags  (flags),
    .CondEx (cond_ex)
  );

  // Only S-suffixed, condition-passing data-processing ops update flags;
  // C/V are left alone by logical operations.
  assign in_exec    = (state == S_EXECR) || (state == S_EXECI);
  assign flag_we    = in_exec && funct[0] && cond_q;
  assign flag_we_cv = flag_we && ((exec_alu == ALU_ADD) || (exec_alu == ALU_SUB));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_FETCH;
      flags  <= 4'b0000;
      cond_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        cond_q <= cond_ex;
      end
      if (flag_we) begin
        flags[3:2] <= ALUFlags[3:2];
      end
      if (flag_we_cv) begin
        flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_DP:   state_next = funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_next = S_MEMADR;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXECR:  state_next = S_ALUWB;
      S_EXECI:  state_next = S_ALUWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = S_FETCH;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_w      = 1'b1;
        pc_w      = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = cond_q;
        pc_w      = cond_q & rd_is_pc;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = cond_q;
      end
      S_EXECR:  ALUControl = exec_alu;
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = exec_alu;
      end
      S_ALUWB: begin
        reg_w = cond_q;
        pc_w  = cond_q & rd_is_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_w      = cond_q;
      end
      default: ;
    endcase
  end

  // Write enables are killed during reset independently of state.
  assign PCWrite  = pc_w  & reset_n;
  assign IRWrite  = ir_w  & reset_n;
  assign RegWrite = reg_w & reset_n;
  assign MemWrite = mem_w & reset_n;

  assign ImmSrc = op;

  always_comb begin
    RegSrc = 2'b00;
    if (op == OP_BR) begin
      RegSrc = 2'b01;
    end else if ((op == OP_MEM) && !funct[0]) begin
      RegSrc = 2'b10;
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have these ports, one line each.
- clk  in  1  sole clock; all state changes on rising edge.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- Instr  in  32  current instruction from the IR. Uses Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle.
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables.
- AdrSrc, ALUSrcA  out  1 each  mux selects.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  out  2 each  mux selects and ALU operation.
- state_o  out  4  current state encoding, for debug.

Function
REQ-002 The block SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-003 State transitions SHALL be:
- FETCH->DECODE.
- DECODE: Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH.
- MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD->MEMWB.
- EXECR/EXECI->ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
REQ-004 FETCH SHALL drive IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00 (ADD, PC+4).
REQ-005 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10, with no write enables.
REQ-006 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ALUControl=00.
REQ-007 MEMRD SHALL drive AdrSrc=1 and ResultSrc=00.
REQ-008 MEMWB SHALL drive ResultSrc=01 and RegWrite=cond_q.
REQ-009 MEMWR SHALL drive AdrSrc=1 and MemWrite=cond_q.
REQ-010 EXECR SHALL drive ALUSrcA=0 and ALUSrcB=00; EXECI SHALL drive ALUSrcA=0 and ALUSrcB=01.
REQ-011 In EXECR and EXECI, ALUControl SHALL decode Funct[4:1]: 0100=ADD 00, 0010=SUB 01, 0000=AND 10, 1100=ORR 11, other=00.
REQ-012 ALUWB SHALL drive ResultSrc=00 and RegWrite=cond_q.
REQ-013 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10 and PCWrite=cond_q.
REQ-014 ImmSrc SHALL equal Op in every state.
REQ-015 RegSrc SHALL be: Op=10 -> 01; Op=01 with Funct[0]=0 -> 10; otherwise 00.
REQ-016 In MEMWB and ALUWB, when Rd=1111 and cond_q=1, PCWrite SHALL also be 1.
REQ-017 cond_q SHALL be registered at the end of DECODE from the condition check of Cond against the flags register.
REQ-018 cond_q SHALL hold until the next DECODE.
REQ-019 Flags updated in EXECR/EXECI SHALL NOT affect cond_q for the current instruction.
REQ-020 The condition check SHALL implement ARM codes 0000-1110 (EQ..AL); code 1111 SHALL give 0.
REQ-021 In EXECR/EXECI, when Funct[0]=1 and cond_q=1, flags[3:2] SHALL be loaded from ALUFlags[3:2] at the end of the cycle.
REQ-022 Under the same condition, flags[1:0] SHALL be loaded only if ALUControl is 00 or 01.
REQ-023 In all other states the flags register SHALL hold.
REQ-024 All outputs not listed for a state SHALL be 0; no output SHALL be X in any state.
REQ-025 Encodings 10-15 on state SHALL transition to FETCH.

Reset
REQ-026 With reset_n=0 at a rising edge, the block SHALL set state=FETCH, flags=0000 and cond_q=0, abandoning any in-flight instruction.
REQ-027 While reset_n=0, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0 combinationally.
REQ-028 The first edge with reset_n=1 SHALL execute FETCH.

Structure
REQ-029 A shared package SHALL hold the state enum, the ALUControl encodings, the condition-code constants and the Op encodings.
REQ-030 The condition check SHALL be a separate sub-module, cond_check, taking Cond and flags and producing CondEx.
REQ-031 The FSM state register, flags register and cond_q SHALL be the only sequential elements.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- ADD R1,R2,R3 (E0821003) -> states 0,1,6,8; ALUControl=00 in EXECR; RegWrite=1 in ALUWB only.
- LDR (E5921004) -> states 0,1,2,3,4; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB.
- STR (E5821004) -> states 0,1,2,5; MemWrite=1 for exactly one cycle.
- SUBS R0,R0,R0 then BEQ -> flags Z=1; BEQ reaches BRANCH with PCWrite=1. Repeat with flags Z=0: PCWrite=0 in BRANCH.
- ADDNE while Z=1 -> RegWrite stays 0 through ALUWB.
- reset_n low in MEMWR -> next state FETCH, MemWrite=0 on that cycle, flags=0000.
- Op=11 -> FETCH, DECODE, FETCH, with no write enables after FETCH.
